// File: rtl/mux_scan_sequencer_if.sv
// Bundle of scan-control and mux-facing signals for mux_scan_sequencer.
// master: the controller/environment side; slave: the sequencer itself.
interface mux_scan_sequencer_if #(
  parameter int DWELL_W = 4
);
  logic               start;
  logic [3:0]         mask;
  logic [DWELL_W-1:0] dwell;
  logic               y;
  logic               sel1;
  logic               sel0;
  logic               busy;
  logic               valid;
  logic [3:0]         sample;

  modport master (
    output start, mask, dwell, y,
    input  sel1, sel0, busy, valid, sample
  );

  modport slave (
    input  start, mask, dwell, y,
    output sel1, sel0, busy, valid, sample
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Steps a 4:1 analog/digital mux through the enabled channels in ascending
// order, waits dwell+1 settle cycles per channel, captures y, and reports
// the completed frame with a one-cycle valid pulse.
module mux_scan_sequencer #(
  parameter int DWELL_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_scan_sequencer_if.slave  bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETTLE  = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]         state;
  logic [1:0]         ch;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_q;
  logic [3:0]         mask_q;
  logic [3:0]         sample_q;
  logic               busy_q;
  logic               valid_q;

  logic [1:0]         first_ch;
  logic               first_found;
  logic [1:0]         next_ch;
  logic               has_next;

  // Lowest enabled channel of the incoming mask (first channel of a frame)
  always_comb begin
    first_ch    = 2'd0;
    first_found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bus.mask[i] && !first_found) begin
        first_ch    = 2'(i);
        first_found = 1'b1;
      end
    end
  end

  // Next enabled channel above the current one in the latched mask
  always_comb begin
    next_ch  = ch;
    has_next = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (mask_q[i] && (2'(i) > ch) && !has_next) begin
        next_ch  = 2'(i);
        has_next = 1'b1;
      end
    end
  end

  // Frame sequencing; valid is registered from DONE so it appears in the
  // first cycle after DONE, alongside the return to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ch       <= '0;
      cnt      <= '0;
      dwell_q  <= '0;
      mask_q   <= '0;
      sample_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= (state == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            sample_q <= '0;
            if (|bus.mask) begin
              mask_q  <= bus.mask;
              dwell_q <= bus.dwell;
              ch      <= first_ch;
              cnt     <= bus.dwell;
              busy_q  <= 1'b1;
              state   <= SETTLE;
            end else begin
              state <= DONE;
            end
          end
        end
        SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - DWELL_W'(1);
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          sample_q[ch] <= bus.y;
          if (has_next) begin
            ch    <= next_ch;
            cnt   <= dwell_q;
            state <= SETTLE;
          end else begin
            busy_q <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.sel1   = ch[1];
  assign bus.sel0   = ch[0];
  assign bus.busy   = busy_q;
  assign bus.valid  = valid_q;
  assign bus.sample = sample_q;

endmodule
